// File: rtl/uart_apb_csr_pkg.sv
// Shared register map, bit indices and status layout for the UART APB CSR block.
package uart_apb_csr_pkg;

    localparam logic [2:0] OFF_CTRL   = 3'd0;
    localparam logic [2:0] OFF_BAUD   = 3'd1;
    localparam logic [2:0] OFF_STAT   = 3'd2;
    localparam logic [2:0] OFF_TXDATA = 3'd3;
    localparam logic [2:0] OFF_RXDATA = 3'd4;
    localparam logic [2:0] OFF_LEVEL  = 3'd5;
    localparam logic [2:0] OFF_IRQ_EN = 3'd6;

    localparam int CTRL_TX_EN  = 0;
    localparam int CTRL_RX_EN  = 1;
    localparam int CTRL_TX_CLR = 2;
    localparam int CTRL_RX_CLR = 3;

    localparam int STAT_STICKY_LSB = 4;

    typedef struct packed {
        logic tx_ovf;
        logic stop_err;
        logic par_err;
        logic rx_ovr;
        logic rx_empty;
        logic rx_full;
        logic tx_empty;
        logic tx_full;
    } stat_t;

endpackage

// File: rtl/uart_apb_csr_if.sv
// APB slave bus bundle for uart_apb_csr; master drives request, slave drives response.
interface uart_apb_csr_if;
    logic        psel;
    logic        penable;
    logic        pwrite;
    logic [31:0] paddr;
    logic [31:0] pwdata;
    logic [31:0] prdata;
    logic        pready;
    logic        pslverr;

    modport master (output psel, penable, pwrite, paddr, pwdata,
                    input  prdata, pready, pslverr);
    modport slave  (input  psel, penable, pwrite, paddr, pwdata,
                    output prdata, pready, pslverr);
endinterface

// File: rtl/uart_apb_csr_fifo.sv
// First-word-fall-through synchronous FIFO; clear has priority over push/pop,
// and a push while full is rejected even if a pop happens in the same cycle.
module uart_sync_fifo #(
    parameter int WIDTH = 9,
    parameter int DEPTH = 16
) (
    input  logic                     clk_i,
    input  logic                     rst_n_i,
    input  logic                     clr_i,
    input  logic                     push_i,
    input  logic [WIDTH-1:0]         data_i,
    input  logic                     pop_i,
    output logic [WIDTH-1:0]         data_o,
    output logic                     full_o,
    output logic                     empty_o,
    output logic [$clog2(DEPTH):0]   count_o
);
    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [AW:0]      count_q, count_d;
    logic             do_push, do_pop;

    assign full_o  = (count_q == (AW+1)'(DEPTH));
    assign empty_o = (count_q == '0);
    assign do_push = push_i & ~full_o;
    assign do_pop  = pop_i & ~empty_o;
    assign data_o  = mem_q[rd_ptr_q];
    assign count_o = count_q;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (do_push) wr_ptr_d = wr_ptr_q + 1'b1;
        if (do_pop)  rd_ptr_d = rd_ptr_q + 1'b1;
        case ({do_push, do_pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
        if (clr_i) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    always_ff @(posedge clk_i) begin
        if (do_push) mem_q[wr_ptr_q] <= data_i;
    end

endmodule

// File: rtl/uart_apb_csr.sv
// APB control/status and TX/RX buffering between the CPU bus and the UART datapath.
// Optional interrupt output and IRQ_EN register enabled by defining UART_APB_CSR_IRQ_EN.
module uart_apb_csr
    import uart_apb_csr_pkg::*;
#(
    parameter int          DATA_WIDTH = 8,
    parameter int          FIFO_DEPTH = 16,
    parameter logic [16:0] BAUD_RESET = 17'd868
) (
    input  logic                  clk_i,
    input  logic                  rst_n_i,
    uart_apb_csr_if.slave         apb,
    output logic [16:0]           baud_o,
    output logic [DATA_WIDTH-1:0] mst_axis_tdata_o,
    output logic                  mst_axis_tvalid_o,
    output logic                  mst_axis_tlast_o,
    input  logic                  mst_axis_tready_i,
    input  logic [DATA_WIDTH-1:0] slv_axis_tdata_i,
    input  logic                  slv_axis_tvalid_i,
    input  logic                  slv_axis_tlast_i,
    output logic                  slv_axis_tready_o,
    input  logic                  parity_err_i,
    input  logic                  stop_err_i
`ifdef UART_APB_CSR_IRQ_EN
    ,
    output logic                  irq_o
`endif
);
    localparam int EW = DATA_WIDTH + 1;
    localparam int CW = $clog2(FIFO_DEPTH) + 1;

    logic [2:0]  offset;
    logic        setup, access, wr, rd_acc, mapped;
    logic        tx_en_q, tx_en_d, rx_en_q, rx_en_d;
    logic [16:0] baud_q, baud_d;
    logic [3:0]  sticky_q, sticky_d, sticky_set, sticky_w1c;
    logic [31:0] prdata_q, prdata_d, rdata;
    logic        tx_clr, rx_clr, tx_push, tx_pop, rx_push, rx_pop;
    logic        tx_full, tx_empty, rx_full, rx_empty;
    logic [EW-1:0] tx_head, rx_head;
    logic [CW-1:0] tx_count, rx_count;
    stat_t       stat;
    logic        unused_ok;

    assign offset = apb.paddr[4:2];
    assign setup  = apb.psel & ~apb.penable;
    assign access = apb.psel & apb.penable;
    assign wr     = access & apb.pwrite;
    assign rd_acc = access & ~apb.pwrite;

`ifdef UART_APB_CSR_IRQ_EN
    assign mapped = (offset <= OFF_IRQ_EN);
`else
    assign mapped = (offset <= OFF_LEVEL);
`endif

    assign apb.prdata  = prdata_q;
    assign apb.pready  = 1'b1;
    assign apb.pslverr = access & ~mapped;
    assign unused_ok   = ^{apb.paddr[31:5], apb.paddr[1:0], apb.pwdata[31:17]};

    // Clears act in the write cycle itself so the FIFO is empty on the next edge.
    assign tx_clr  = wr & (offset == OFF_CTRL) & apb.pwdata[CTRL_TX_CLR];
    assign rx_clr  = wr & (offset == OFF_CTRL) & apb.pwdata[CTRL_RX_CLR];
    assign tx_push = wr & (offset == OFF_TXDATA) & ~tx_full;
    assign tx_pop  = mst_axis_tvalid_o & mst_axis_tready_i;
    assign rx_push = rx_en_q & slv_axis_tvalid_i & ~rx_full;
    // Pop only if the setup-phase snapshot actually carried a beat.
    assign rx_pop  = rd_acc & (offset == OFF_RXDATA) & prdata_q[31] & ~rx_empty;

    assign mst_axis_tvalid_o = tx_en_q & ~tx_empty;
    assign mst_axis_tdata_o  = tx_head[DATA_WIDTH-1:0];
    assign mst_axis_tlast_o  = tx_head[DATA_WIDTH];
    assign slv_axis_tready_o = ~rx_en_q | ~rx_full;
    assign baud_o            = baud_q;

    uart_sync_fifo #(.WIDTH(EW), .DEPTH(FIFO_DEPTH)) u_tx_fifo (
        .clk_i   (clk_i),
        .rst_n_i (rst_n_i),
        .clr_i   (tx_clr),
        .push_i  (tx_push),
        .data_i  (apb.pwdata[DATA_WIDTH:0]),
        .pop_i   (tx_pop),
        .data_o  (tx_head),
        .full_o  (tx_full),
        .empty_o (tx_empty),
        .count_o (tx_count)
    );

    uart_sync_fifo #(.WIDTH(EW), .DEPTH(FIFO_DEPTH)) u_rx_fifo (
        .clk_i   (clk_i),
        .rst_n_i (rst_n_i),
        .clr_i   (rx_clr),
        .push_i  (rx_push),
        .data_i  ({slv_axis_tlast_i, slv_axis_tdata_i}),
        .pop_i   (rx_pop),
        .data_o  (rx_head),
        .full_o  (rx_full),
        .empty_o (rx_empty),
        .count_o (rx_count)
    );

    assign sticky_set = {wr & (offset == OFF_TXDATA) & tx_full,
                         stop_err_i,
                         parity_err_i,
                         rx_en_q & rx_full & slv_axis_tvalid_i};
    assign sticky_w1c = (wr && offset == OFF_STAT) ? apb.pwdata[STAT_STICKY_LSB +: 4] : 4'b0;

    assign stat = '{tx_ovf:   sticky_q[3],
                    stop_err: sticky_q[2],
                    par_err:  sticky_q[1],
                    rx_ovr:   sticky_q[0],
                    rx_empty: rx_empty,
                    rx_full:  rx_full,
                    tx_empty: tx_empty,
                    tx_full:  tx_full};

`ifdef UART_APB_CSR_IRQ_EN
    logic [2:0] irq_en_q, irq_en_d;
    logic       irq_q, irq_d;

    assign irq_en_d = (wr && offset == OFF_IRQ_EN) ? apb.pwdata[2:0] : irq_en_q;
    assign irq_d    = |(irq_en_q & {|sticky_q, tx_empty, ~rx_empty});
    assign irq_o    = irq_q;

    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            irq_en_q <= '0;
            irq_q    <= 1'b0;
        end else begin
            irq_en_q <= irq_en_d;
            irq_q    <= irq_d;
        end
    end
`endif

    always_comb begin
        rdata = '0;
        case (offset)
            OFF_CTRL:   rdata = {30'b0, rx_en_q, tx_en_q};
            OFF_BAUD:   rdata = {15'b0, baud_q};
            OFF_STAT:   rdata = {24'b0, stat};
            OFF_RXDATA: if (!rx_empty) begin
                rdata[EW-1:0] = rx_head;
                rdata[31]     = 1'b1;
            end
            OFF_LEVEL:  rdata = {16'(rx_count), 16'(tx_count)};
`ifdef UART_APB_CSR_IRQ_EN
            OFF_IRQ_EN: rdata = {29'b0, irq_en_q};
`endif
            default:    rdata = '0;
        endcase
    end

    always_comb begin
        tx_en_d  = tx_en_q;
        rx_en_d  = rx_en_q;
        baud_d   = baud_q;
        prdata_d = setup ? rdata : prdata_q;
        sticky_d = (sticky_q & ~sticky_w1c) | sticky_set;
        if (wr && offset == OFF_CTRL) begin
            tx_en_d = apb.pwdata[CTRL_TX_EN];
            rx_en_d = apb.pwdata[CTRL_RX_EN];
        end
        if (wr && offset == OFF_BAUD) baud_d = apb.pwdata[16:0];
    end

    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            tx_en_q  <= 1'b1;
            rx_en_q  <= 1'b1;
            baud_q   <= BAUD_RESET;
            sticky_q <= '0;
            prdata_q <= '0;
        end else begin
            tx_en_q  <= tx_en_d;
            rx_en_q  <= rx_en_d;
            baud_q   <= baud_d;
            sticky_q <= sticky_d;
            prdata_q <= prdata_d;
        end
    end

endmodule

// File: tb/tb_uart_apb_csr.sv
// Directed self-checking bench for uart_apb_csr: register map, TX/RX buffering and status.
module tb_uart_apb_csr;
    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [16:0] baud;
    logic [7:0] mst_tdata, slv_tdata = '0;
    logic       mst_tvalid, mst_tlast, mst_tready = 1'b0;
    logic       slv_tvalid = 1'b0, slv_tlast = 1'b0, slv_tready;
    logic       parity_err = 1'b0, stop_err = 1'b0;
    int         errors = 0;
    int         checks = 0;
    logic [8:0] beats[$];
`ifdef UART_APB_CSR_IRQ_EN
    logic       irq;
`endif

    uart_apb_csr_if apb();

    uart_apb_csr dut (
        .clk_i             (clk),
        .rst_n_i           (rst_n),
        .apb               (apb),
        .baud_o            (baud),
        .mst_axis_tdata_o  (mst_tdata),
        .mst_axis_tvalid_o (mst_tvalid),
        .mst_axis_tlast_o  (mst_tlast),
        .mst_axis_tready_i (mst_tready),
        .slv_axis_tdata_i  (slv_tdata),
        .slv_axis_tvalid_i (slv_tvalid),
        .slv_axis_tlast_i  (slv_tlast),
        .slv_axis_tready_o (slv_tready),
        .parity_err_i      (parity_err),
        .stop_err_i        (stop_err)
`ifdef UART_APB_CSR_IRQ_EN
        ,
        .irq_o             (irq)
`endif
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (rst_n && mst_tvalid && mst_tready) beats.push_back({mst_tlast, mst_tdata});
    end

    task automatic apb_wr(input logic [31:0] a, input logic [31:0] d);
        @(negedge clk);
        apb.psel = 1'b1; apb.penable = 1'b0; apb.pwrite = 1'b1; apb.paddr = a; apb.pwdata = d;
        @(negedge clk);
        apb.penable = 1'b1;
        @(negedge clk);
        apb.psel = 1'b0; apb.penable = 1'b0; apb.pwrite = 1'b0;
    endtask

    task automatic apb_rd(input logic [31:0] a, output logic [31:0] d, output logic e);
        @(negedge clk);
        apb.psel = 1'b1; apb.penable = 1'b0; apb.pwrite = 1'b0; apb.paddr = a;
        @(negedge clk);
        apb.penable = 1'b1;
        #1;
        d = apb.prdata;
        e = apb.pslverr;
        @(negedge clk);
        apb.psel = 1'b0; apb.penable = 1'b0;
    endtask

    task automatic test_reset();
        logic [31:0] d; logic e;
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        #1;
        checks++; if (mst_tvalid !== 1'b0) begin errors++; $display("FAIL rst_tvalid: got %b want 0", mst_tvalid); end
        checks++; if (slv_tready !== 1'b1) begin errors++; $display("FAIL rst_tready: got %b want 1", slv_tready); end
        checks++; if (apb.prdata !== 32'h0) begin errors++; $display("FAIL rst_prdata: got %h want 0", apb.prdata); end
        checks++; if (apb.pslverr !== 1'b0) begin errors++; $display("FAIL rst_pslverr: got %b want 0", apb.pslverr); end
        rst_n = 1'b1;
        apb_rd(32'h00, d, e);
        checks++; if (d !== 32'h3) begin errors++; $display("FAIL rst_ctrl: got %h want 3", d); end
        apb_rd(32'h04, d, e);
        checks++; if (d !== 32'd868) begin errors++; $display("FAIL rst_baud: got %0d want 868", d); end
        apb_rd(32'h08, d, e);
        checks++; if (d !== 32'h0A) begin errors++; $display("FAIL rst_stat: got %h want 0a", d); end
        apb_rd(32'h14, d, e);
        checks++; if (d !== 32'h0) begin errors++; $display("FAIL rst_level: got %h want 0", d); end
`ifdef UART_APB_CSR_IRQ_EN
        checks++; if (irq !== 1'b0) begin errors++; $display("FAIL rst_irq: got %b want 0", irq); end
`endif
    endtask

    task automatic test_baud();
        logic [31:0] d; logic e;
        apb_wr(32'h04, 32'hFFFF_FFFF);
        apb_rd(32'h04, d, e);
        checks++; if (d !== 32'h1FFFF) begin errors++; $display("FAIL baud_rd: got %h want 1ffff", d); end
        checks++; if (baud !== 17'h1FFFF) begin errors++; $display("FAIL baud_o: got %h want 1ffff", baud); end
        apb_wr(32'h04, 32'd868);
        checks++; if (baud !== 17'd868) begin errors++; $display("FAIL baud_restore: got %0d want 868", baud); end
    endtask

    task automatic test_tx_order();
        beats.delete();
        mst_tready = 1'b1;
        apb_wr(32'h0C, 32'h155);
        apb_wr(32'h0C, 32'h0AA);
        repeat (4) @(negedge clk);
        checks++; if (beats.size() !== 2) begin errors++; $display("FAIL tx_order_n: got %0d want 2", beats.size()); end
        if (beats.size() == 2) begin
            checks++; if (beats[0] !== 9'h155) begin errors++; $display("FAIL tx_beat0: got %h want 155", beats[0]); end
            checks++; if (beats[1] !== 9'h0AA) begin errors++; $display("FAIL tx_beat1: got %h want 0aa", beats[1]); end
        end
        checks++; if (mst_tvalid !== 1'b0) begin errors++; $display("FAIL tx_idle_tvalid: got %b want 0", mst_tvalid); end
        beats.delete();
    endtask

    task automatic test_tx_enable();
        logic [31:0] d; logic e;
        mst_tready = 1'b0;
        apb_wr(32'h0C, 32'h011);
        apb_wr(32'h0C, 32'h022);
        apb_wr(32'h00, 32'h2);
        #1;
        checks++; if (mst_tvalid !== 1'b0) begin errors++; $display("FAIL txen_off_tvalid: got %b want 0", mst_tvalid); end
        mst_tready = 1'b1;
        repeat (3) @(negedge clk);
        apb_rd(32'h14, d, e);
        checks++; if (d !== 32'h2) begin errors++; $display("FAIL txen_off_level: got %h want 2", d); end
        checks++; if (beats.size() !== 0) begin errors++; $display("FAIL txen_off_beats: got %0d want 0", beats.size()); end
        apb_wr(32'h00, 32'h3);
        repeat (3) @(negedge clk);
        checks++; if (beats.size() !== 2) begin errors++; $display("FAIL txen_on_beats: got %0d want 2", beats.size()); end
        if (beats.size() == 2) begin
            checks++; if (beats[1] !== 9'h022) begin errors++; $display("FAIL txen_beat1: got %h want 022", beats[1]); end
        end
        mst_tready = 1'b0;
        beats.delete();
    endtask

    task automatic test_tx_overflow_clear();
        logic [31:0] d; logic e;
        mst_tready = 1'b0;
        for (int i = 0; i < 17; i++) apb_wr(32'h0C, 32'(i));
        apb_rd(32'h14, d, e);
        checks++; if (d[15:0] !== 16'd16) begin errors++; $display("FAIL ovf_level: got %0d want 16", d[15:0]); end
        apb_rd(32'h08, d, e);
        checks++; if (d !== 32'h89) begin errors++; $display("FAIL ovf_stat: got %h want 89", d); end
        checks++; if ({mst_tvalid, mst_tlast, mst_tdata} !== 10'h200) begin
            errors++; $display("FAIL ovf_head: got %h want 200", {mst_tvalid, mst_tlast, mst_tdata}); end
        apb_wr(32'h08, 32'h80);
        apb_rd(32'h08, d, e);
        checks++; if (d !== 32'h09) begin errors++; $display("FAIL ovf_w1c: got %h want 09", d); end
        apb_wr(32'h00, 32'h7);
        apb_rd(32'h14, d, e);
        checks++; if (d !== 32'h0) begin errors++; $display("FAIL clr_level: got %h want 0", d); end
        apb_rd(32'h00, d, e);
        checks++; if (d !== 32'h3) begin errors++; $display("FAIL clr_ctrl_rd: got %h want 3", d); end
        // Clear coinciding with a pending pop
        for (int i = 0; i < 5; i++) apb_wr(32'h0C, 32'h40 + 32'(i));
        @(negedge clk);
        apb.psel = 1'b1; apb.penable = 1'b0; apb.pwrite = 1'b1; apb.paddr = 32'h00; apb.pwdata = 32'h7;
        @(negedge clk);
        apb.penable = 1'b1; mst_tready = 1'b1;
        @(posedge clk);
        #1;
        checks++; if (mst_tvalid !== 1'b0) begin errors++; $display("FAIL clrpop_tvalid: got %b want 0", mst_tvalid); end
        @(negedge clk);
        apb.psel = 1'b0; apb.penable = 1'b0; apb.pwrite = 1'b0; mst_tready = 1'b0;
        apb_rd(32'h14, d, e);
        checks++; if (d !== 32'h0) begin errors++; $display("FAIL clrpop_level: got %h want 0", d); end
        beats.delete();
    endtask

    task automatic test_rx();
        logic [31:0] d; logic e;
        @(negedge clk);
        slv_tvalid = 1'b1; slv_tdata = 8'h3C; slv_tlast = 1'b1;
        @(negedge clk);
        slv_tvalid = 1'b0; slv_tlast = 1'b0;
        apb_rd(32'h10, d, e);
        checks++; if (d !== 32'h8000013C) begin errors++; $display("FAIL rx_first: got %h want 8000013c", d); end
        apb_rd(32'h10, d, e);
        checks++; if (d !== 32'h0) begin errors++; $display("FAIL rx_empty_rd: got %h want 0", d); end
        apb_wr(32'h00, 32'h1);
        @(negedge clk);
        slv_tvalid = 1'b1; slv_tdata = 8'h77;
        #1;
        checks++; if (slv_tready !== 1'b1) begin errors++; $display("FAIL rxdis_tready: got %b want 1", slv_tready); end
        @(negedge clk);
        slv_tvalid = 1'b0;
        apb_rd(32'h14, d, e);
        checks++; if (d !== 32'h0) begin errors++; $display("FAIL rxdis_level: got %h want 0", d); end
        apb_wr(32'h00, 32'h3);
        for (int i = 0; i < 16; i++) begin
            @(negedge clk);
            slv_tvalid = 1'b1; slv_tdata = 8'(i); slv_tlast = 1'b0;
        end
        @(negedge clk);
        slv_tdata = 8'h99; slv_tlast = 1'b1;
        #1;
        checks++; if (slv_tready !== 1'b0) begin errors++; $display("FAIL rxfull_tready: got %b want 0", slv_tready); end
        apb_rd(32'h08, d, e);
        checks++; if (d !== 32'h16) begin errors++; $display("FAIL rxovr_stat: got %h want 16", d); end
        apb_rd(32'h14, d, e);
        checks++; if (d !== 32'h0010_0000) begin errors++; $display("FAIL rxfull_level: got %h want 00100000", d); end
        apb_rd(32'h10, d, e);
        checks++; if (d !== 32'h8000_0000) begin errors++; $display("FAIL rx_pop0: got %h want 80000000", d); end
        @(negedge clk);
        slv_tvalid = 1'b0; slv_tlast = 1'b0;
        for (int i = 1; i < 16; i++) begin
            apb_rd(32'h10, d, e);
            checks++; if (d !== (32'h8000_0000 | 32'(i))) begin
                errors++; $display("FAIL rx_drain%0d: got %h want %h", i, d, 32'h8000_0000 | 32'(i)); end
        end
        apb_rd(32'h10, d, e);
        checks++; if (d !== 32'h8000_0199) begin errors++; $display("FAIL rx_stalled: got %h want 80000199", d); end
        apb_rd(32'h10, d, e);
        checks++; if (d !== 32'h0) begin errors++; $display("FAIL rx_drained: got %h want 0", d); end
        apb_wr(32'h08, 32'h10);
        apb_rd(32'h08, d, e);
        checks++; if (d !== 32'h0A) begin errors++; $display("FAIL rxovr_w1c: got %h want 0a", d); end
    endtask

    task automatic test_sticky();
        logic [31:0] d; logic e;
        @(negedge clk); parity_err = 1'b1;
        @(negedge clk); parity_err = 1'b0;
        apb_rd(32'h08, d, e);
        checks++; if (d !== 32'h2A) begin errors++; $display("FAIL par_set: got %h want 2a", d); end
        @(negedge clk);
        apb.psel = 1'b1; apb.penable = 1'b0; apb.pwrite = 1'b1; apb.paddr = 32'h08; apb.pwdata = 32'h20;
        @(negedge clk);
        apb.penable = 1'b1; parity_err = 1'b1;
        @(negedge clk);
        apb.psel = 1'b0; apb.penable = 1'b0; apb.pwrite = 1'b0; parity_err = 1'b0;
        apb_rd(32'h08, d, e);
        checks++; if (d !== 32'h2A) begin errors++; $display("FAIL par_set_wins: got %h want 2a", d); end
        apb_wr(32'h08, 32'h20);
        apb_rd(32'h08, d, e);
        checks++; if (d !== 32'h0A) begin errors++; $display("FAIL par_w1c: got %h want 0a", d); end
        apb_wr(32'h00, 32'h1);
        @(negedge clk); stop_err = 1'b1;
        @(negedge clk); stop_err = 1'b0;
        apb_rd(32'h08, d, e);
        checks++; if (d !== 32'h4A) begin errors++; $display("FAIL stop_set: got %h want 4a", d); end
        apb_wr(32'h08, 32'h40);
        apb_wr(32'h00, 32'h3);
        apb_rd(32'h08, d, e);
        checks++; if (d !== 32'h0A) begin errors++; $display("FAIL stop_w1c: got %h want 0a", d); end
    endtask

    task automatic test_decode();
        logic [31:0] d; logic e;
        apb_rd(32'h1C, d, e);
        checks++; if (e !== 1'b1) begin errors++; $display("FAIL slverr_1c: got %b want 1", e); end
        apb_rd(32'h14, d, e);
        checks++; if (e !== 1'b0) begin errors++; $display("FAIL slverr_14: got %b want 0", e); end
        apb_rd(32'h0C, d, e);
        checks++; if (d !== 32'h0) begin errors++; $display("FAIL txdata_rd: got %h want 0", d); end
        apb_rd(32'h18, d, e);
`ifdef UART_APB_CSR_IRQ_EN
        checks++; if (e !== 1'b0) begin errors++; $display("FAIL slverr_18: got %b want 0", e); end
        apb_wr(32'h18, 32'h2);
        repeat (2) @(negedge clk);
        checks++; if (irq !== 1'b1) begin errors++; $display("FAIL irq_txempty: got %b want 1", irq); end
        apb_wr(32'h18, 32'h0);
`else
        checks++; if (e !== 1'b1) begin errors++; $display("FAIL slverr_18: got %b want 1", e); end
`endif
    endtask

    task automatic test_reset_mid();
        logic [31:0] d; logic e;
        mst_tready = 1'b0;
        apb_wr(32'h0C, 32'h1A5);
        apb_wr(32'h0C, 32'h05A);
        apb_wr(32'h00, 32'h0);
        apb_wr(32'h00, 32'h1);
        checks++; if (mst_tvalid !== 1'b1) begin errors++; $display("FAIL mid_pre_tvalid: got %b want 1", mst_tvalid); end
        @(negedge clk); rst_n = 1'b0;
        @(negedge clk); #1;
        checks++; if (mst_tvalid !== 1'b0) begin errors++; $display("FAIL mid_tvalid: got %b want 0", mst_tvalid); end
        rst_n = 1'b1;
        apb_rd(32'h14, d, e);
        checks++; if (d !== 32'h0) begin errors++; $display("FAIL mid_level: got %h want 0", d); end
        apb_rd(32'h00, d, e);
        checks++; if (d !== 32'h3) begin errors++; $display("FAIL mid_ctrl: got %h want 3", d); end
        checks++; if (beats.size() !== 0) begin errors++; $display("FAIL mid_beats: got %0d want 0", beats.size()); end
    endtask

    initial begin
        apb.psel = 1'b0; apb.penable = 1'b0; apb.pwrite = 1'b0;
        apb.paddr = '0; apb.pwdata = '0;
        test_reset();
        test_baud();
        test_tx_order();
        test_tx_enable();
        test_tx_overflow_clear();
        test_rx();
        test_sticky();
        test_decode();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
